// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
//
// Round-robin scheduler that time-shares one max-count counter between NREQ
// timer clients. A client raises req[i] with a length in len[i]; when granted,
// the scheduler enables the shared counter with max = len[i]. It waits for the
// counter's carry-out and then returns a one-cycle done[i] pulse. The enable
// is high for exactly len+1 cycles.
//
// Ports
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (also resets the shared counter)
//   req      in   NREQ    level request per client, held until its done
//   len      in   NREQ*DW packed lengths, client i at [i*DW +: DW]
//   grant    out  NREQ    one-hot current owner, zero when idle
//   gidx     out  IW      index of current owner, zero when idle
//   done     out  NREQ    one-hot one-cycle completion pulse
//   busy     out  1       high while running or signalling done
//   cnt_en   out  1       shared counter enable
//   cnt_max  out  DW      shared counter terminal value
//   cnt_co   in   1       shared counter carry-out (en & cnt == max)
// -----------------------------------------------------------------------------
module counter_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic [IW-1:0]      gidx,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               cnt_en,
  output logic [DW-1:0]      cnt_max,
  input  logic               cnt_co
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;     // highest-priority requester for the next arbitration

  logic          found;
  logic [IW-1:0] winner;

  // First set request searching upward from ptr with wrap-around. The loop
  // runs from the far end back toward ptr so the closest hit is written last.
  always_comb begin
    int j;
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it holding its old value and infer a latch.
    found  = 1'b0;
    winner = '0;
    j      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
  end

  // Single registered FSM; every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      gidx    <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt_en  <= 1'b0;
      cnt_max <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= RUN;
            grant   <= NREQ'(1) << winner;
            gidx    <= winner;
            cnt_max <= len[int'(winner)*DW +: DW];
            cnt_en  <= 1'b1;
            busy    <= 1'b1;
          end
        end

        RUN: begin
          // grant, gidx and cnt_max stay latched; later len changes are ignored.
          if (cnt_co) begin
            state   <= DONE;
            done    <= grant;
            grant   <= '0;
            gidx    <= '0;
            cnt_max <= '0;
            cnt_en  <= 1'b0;
            // The finished owner drops to lowest priority.
            ptr     <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end
        end

        DONE: begin
          // req is not sampled here; arbitration resumes from IDLE.
          state <= IDLE;
          done  <= '0;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          grant   <= '0;
          gidx    <= '0;
          done    <= '0;
          busy    <= 1'b0;
          cnt_en  <= 1'b0;
          cnt_max <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_scheduler
//
// Self-checking bench for counter_scheduler. It contains a behavioural model of
// the shared max-count counter that the DUT drives. Expected grant order,
// enable durations and spacing come from round-robin arithmetic kept in the
// bench (model_ptr plus a pending mask).
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] len = '0;
  logic [NREQ-1:0]    grant;
  logic [IW-1:0]      gidx;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               cnt_en;
  logic [DW-1:0]      cnt_max;
  logic               cnt_co;

  logic [DW-1:0]      cnt;
  logic               co_inject = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int inv_err  = 0;
  int model_ptr = 0;

  counter_scheduler #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len), .grant(grant), .gidx(gidx),
    .done(done), .busy(busy), .cnt_en(cnt_en), .cnt_max(cnt_max), .cnt_co(cnt_co)
  );

  always #5 clk = ~clk;

  // Shared counter: wraps to 0 after max, reset by the same rst_n.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (cnt_en) cnt <= (cnt == cnt_max) ? '0 : cnt + 1'b1;
  end
  assign cnt_co = (cnt_en && (cnt == cnt_max)) || co_inject;

  // Structural invariants sampled every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(grant) > 1 || $countones(done) > 1 || (grant & done) != '0 ||
          cnt_en != (|grant) || busy != ((|grant) || (|done)) ||
          (grant == '0 && gidx != '0))
        inv_err++;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic do_reset();
    rst_n = 1'b0; req = '0; len = '0; co_inject = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Steps negedges until a grant is visible; steps counts samples taken.
  task automatic wait_grant(input int limit, output int steps, output bit to);
    steps = 0; to = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      steps++;
      if (grant != '0) begin to = 1'b0; break; end
    end
  endtask

  // From the current sample, counts enabled cycles until done is seen.
  task automatic wait_done(input bit drop, input int limit, output int en_cycles,
                           output logic [NREQ-1:0] done_v, output bit to);
    en_cycles = 0; done_v = '0; to = 1'b1;
    for (int k = 0; k < limit; k++) begin
      if (done != '0) begin
        done_v = done; to = 1'b0;
        if (drop) req = req & ~done;
        break;
      end
      if (cnt_en) en_cycles++;
      @(negedge clk);
    end
  endtask

  // Round-robin winner from the spec rule: first set bit from ptr upward.
  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int i = 0; i < NREQ; i++)
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({grant, done, cnt_en, busy, gidx, cnt_max} !== '0) $display("FAIL reset_outputs: got grant=%b done=%b en=%b busy=%b gidx=%0d max=%0d want all 0", grant, done, cnt_en, busy, gidx, cnt_max); else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if ({grant, done, cnt_en, busy} !== '0) $display("FAIL idle_outputs: got grant=%b done=%b en=%b busy=%b want 0", grant, done, cnt_en, busy); else n_pass++;
    n_checks++; if (cnt !== '0) $display("FAIL idle_cnt: got %0d want 0", cnt); else n_pass++;
  endtask

  task automatic test_single();
    int steps, en; logic [NREQ-1:0] dv; bit to;
    len[2*DW +: DW] = 8'd5; req = 4'b0100;
    wait_grant(8, steps, to);
    n_checks++; if (to || steps != 1) $display("FAIL single_latency: got steps=%0d timeout=%0d want 1", steps, to); else n_pass++;
    n_checks++; if (grant !== 4'b0100 || gidx !== 2'd2 || cnt_max !== 8'd5) $display("FAIL single_grant: got grant=%b gidx=%0d max=%0d want 0100/2/5", grant, gidx, cnt_max); else n_pass++;
    n_checks++; if (cnt !== '0) $display("FAIL single_cnt_start: got %0d want 0", cnt); else n_pass++;
    wait_done(1'b1, 20, en, dv, to);
    n_checks++; if (to || en != 6) $display("FAIL single_en_cycles: got %0d timeout=%0d want 6", en, to); else n_pass++;
    n_checks++; if (dv !== 4'b0100 || busy !== 1'b1) $display("FAIL single_done: got done=%b busy=%b want 0100/1", dv, busy); else n_pass++;
    n_checks++; if (cnt !== '0) $display("FAIL single_cnt_wrap: got %0d want 0", cnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== '0 || busy !== 1'b0) $display("FAIL single_done_width: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
    model_ptr = 3;
  endtask

  task automatic test_min_max();
    int steps, en; logic [NREQ-1:0] dv; bit to;
    @(negedge clk);
    len[0 +: DW] = 8'd0; req = 4'b0001;
    wait_grant(8, steps, to);
    wait_done(1'b1, 10, en, dv, to);
    n_checks++; if (to || en != 1 || dv !== 4'b0001) $display("FAIL min_len: got en=%0d done=%b timeout=%0d want 1/0001", en, dv, to); else n_pass++;
    repeat (2) @(negedge clk);
    len[3*DW +: DW] = 8'd255; req = 4'b1000;
    wait_grant(8, steps, to);
    wait_done(1'b1, 400, en, dv, to);
    n_checks++; if (to || en != 256 || dv !== 4'b1000) $display("FAIL max_len: got en=%0d done=%b timeout=%0d want 256/1000", en, dv, to); else n_pass++;
    model_ptr = 0;
  endtask

  task automatic test_fairness();
    int steps, en; logic [NREQ-1:0] dv; bit to;
    int exp_w;
    do_reset();
    for (int i = 0; i < NREQ; i++) len[i*DW +: DW] = 8'd1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_w = rr_pick(4'b1111, model_ptr);
      wait_grant(10, steps, to);
      n_checks++; if (to || steps != (k == 0 ? 1 : 2)) $display("FAIL fair_gap_%0d: got steps=%0d timeout=%0d want %0d", k, steps, to, (k == 0 ? 1 : 2)); else n_pass++;
      n_checks++; if (gidx !== IW'(exp_w)) $display("FAIL fair_order_%0d: got gidx=%0d want %0d", k, gidx, exp_w); else n_pass++;
      wait_done(1'b0, 10, en, dv, to);
      n_checks++; if (to || en != 2 || dv !== NREQ'(1 << exp_w)) $display("FAIL fair_run_%0d: got en=%0d done=%b want 2/%b", k, en, dv, NREQ'(1 << exp_w)); else n_pass++;
      model_ptr = (exp_w + 1) % NREQ;
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_robust();
    int steps, en; logic [NREQ-1:0] dv; bit to;
    len[1*DW +: DW] = 8'd3; req = 4'b0010;
    wait_grant(8, steps, to);
    @(negedge clk);
    req = '0; len[1*DW +: DW] = 8'd9;
    wait_done(1'b1, 20, en, dv, to);
    n_checks++; if (to || en + 1 != 4 || dv !== 4'b0010) $display("FAIL robust_run: got en=%0d done=%b timeout=%0d want 4/0010", en + 1, dv, to); else n_pass++;
    model_ptr = 2;
    repeat (2) @(negedge clk);
    co_inject = 1'b1;
    @(negedge clk);
    co_inject = 1'b0;
    @(negedge clk);
    n_checks++; if ({grant, done, cnt_en, busy} !== '0) $display("FAIL idle_co: got grant=%b done=%b en=%b busy=%b want 0", grant, done, cnt_en, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int steps, en, dones; logic [NREQ-1:0] dv; bit to;
    len[3*DW +: DW] = 8'd10; req = 4'b1000;
    wait_grant(8, steps, to);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    n_checks++; if ({grant, done, cnt_en, busy, gidx, cnt_max} !== '0) $display("FAIL midrst_outputs: got grant=%b done=%b en=%b busy=%b want 0", grant, done, cnt_en, busy); else n_pass++;
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (done != '0) dones++; end
    n_checks++; if (dones != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", dones); else n_pass++;
    model_ptr = 0;
    len[1*DW +: DW] = 8'd2; len[3*DW +: DW] = 8'd4; req = 4'b1010;
    wait_grant(8, steps, to);
    n_checks++; if (to || gidx !== 2'd1 || cnt !== '0) $display("FAIL midrst_restart: got gidx=%0d cnt=%0d want 1/0", gidx, cnt); else n_pass++;
    wait_done(1'b1, 20, en, dv, to);
    n_checks++; if (to || en != 3 || dv !== 4'b0010) $display("FAIL midrst_run1: got en=%0d done=%b want 3/0010", en, dv); else n_pass++;
    wait_grant(8, steps, to);
    wait_done(1'b1, 20, en, dv, to);
    n_checks++; if (to || en != 5 || dv !== 4'b1000) $display("FAIL midrst_run3: got en=%0d done=%b want 5/1000", en, dv); else n_pass++;
    model_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int steps, en, w; logic [NREQ-1:0] dv, pend; bit to;
    logic [DW-1:0] lv [NREQ];
    do_reset();
    for (int r = 0; r < 8; r++) begin
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        lv[i] = DW'($urandom_range(0, 15));
        len[i*DW +: DW] = lv[i];
      end
      req = pend;
      for (int k = 0; pend != '0; k++) begin
        w = rr_pick(pend, model_ptr);
        wait_grant(10, steps, to);
        n_checks++; if (to || steps != (k == 0 ? 1 : 2) || gidx !== IW'(w) || grant !== NREQ'(1 << w) || cnt_max !== lv[w])
          $display("FAIL rand_grant_r%0d_k%0d: got steps=%0d gidx=%0d grant=%b max=%0d want %0d/%0d/%b/%0d", r, k, steps, gidx, grant, cnt_max, (k == 0 ? 1 : 2), w, NREQ'(1 << w), lv[w]);
        else n_pass++;
        wait_done(1'b1, 40, en, dv, to);
        n_checks++; if (to || en != int'(lv[w]) + 1 || dv !== NREQ'(1 << w)) $display("FAIL rand_run_r%0d_k%0d: got en=%0d done=%b want %0d/%b", r, k, en, dv, int'(lv[w]) + 1, NREQ'(1 << w)); else n_pass++;
        pend[w] = 1'b0;
        model_ptr = (w + 1) % NREQ;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_invariants();
    n_checks++; if (inv_err != 0) $display("FAIL invariants: got %0d violating cycles want 0", inv_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_max();
    test_fairness();
    test_robust();
    test_reset_mid_run();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
